// File: rtl/bottleneck_arbiter_if.sv
// Bundle of the two KCP53K requester ports (I-fetch, D-data) and the
// Bottleneck bridge master port shared between them.
// The slave modport is the arbiter's view; master is the view of
// whatever drives the requesters and plays the bridge.
interface bottleneck_arbiter_if;
  // I-fetch port
  logic        ICycI;
  logic        IStbI;
  logic [63:0] IAdrI;
  logic [1:0]  ISizI;
  logic        ISignedI;
  logic        IAckO;
  logic        IErrAlignO;
  logic        IErrTimeoutO;
  // D-data port
  logic        DCycI;
  logic        DStbI;
  logic        DWeI;
  logic        DSignedI;
  logic [63:0] DAdrI;
  logic [1:0]  DSizI;
  logic [63:0] DDatI;
  logic        DAckO;
  logic        DErrAlignO;
  logic        DErrTimeoutO;
  // Shared read data
  logic [63:0] RDatO;
  // Bridge master port
  logic        MCycO;
  logic        MStbO;
  logic        MWeO;
  logic        MSignedO;
  logic [63:0] MAdrO;
  logic [1:0]  MSizO;
  logic [63:0] MDatO;
  logic        MAckI;
  logic        MErrAlignI;
  logic [63:0] MDatI;

  modport slave (
    input  ICycI, IStbI, IAdrI, ISizI, ISignedI,
    output IAckO, IErrAlignO, IErrTimeoutO,
    input  DCycI, DStbI, DWeI, DSignedI, DAdrI, DSizI, DDatI,
    output DAckO, DErrAlignO, DErrTimeoutO,
    output RDatO,
    output MCycO, MStbO, MWeO, MSignedO, MAdrO, MSizO, MDatO,
    input  MAckI, MErrAlignI, MDatI
  );

  modport master (
    output ICycI, IStbI, IAdrI, ISizI, ISignedI,
    input  IAckO, IErrAlignO, IErrTimeoutO,
    output DCycI, DStbI, DWeI, DSignedI, DAdrI, DSizI, DDatI,
    input  DAckO, DErrAlignO, DErrTimeoutO,
    input  RDatO,
    input  MCycO, MStbO, MWeO, MSignedO, MAdrO, MSizO, MDatO,
    output MAckI, MErrAlignI, MDatI
  );
endinterface

// File: rtl/bottleneck_arbiter.sv
// Two-master round-robin arbiter for the Bottleneck bridge master port.
// Ownership is held for the owner's whole Wishbone cycle; responses are
// steered to the owner only, and a no-ack watchdog flags stalled strobes.
// Bus outputs are combinational from the registered owner so that the
// owner's strobes pass straight through without a bubble.
module bottleneck_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input logic ClkI,
  input logic ResetI,
  bottleneck_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_t;

  state_t        state;
  logic          last_d;   // 1: D was granted last, so I wins the next tie
  logic [CW-1:0] cnt;

  logic req_i;
  logic req_d;
  logic own_i;
  logic own_d;
  logic m_stb;
  logic stalled;
  logic timeout;

  // Request decode, strobe seen by the bridge and watchdog stall detection.
  always_comb begin
    req_i   = bus.ICycI & bus.IStbI;
    req_d   = bus.DCycI & bus.DStbI;
    own_i   = (state == OWN_I);
    own_d   = (state == OWN_D);
    m_stb   = (own_i & bus.ICycI & bus.IStbI) | (own_d & bus.DCycI & bus.DStbI);
    // An ack or alignment error is a response, so it always beats the timeout.
    stalled = m_stb & ~bus.MAckI & ~bus.MErrAlignI;
    timeout = stalled & (cnt == CW'(TIMEOUT - 1));
  end

  // Ownership FSM, round-robin priority and no-ack watchdog counter.
  always_ff @(posedge ClkI or posedge ResetI) begin
    if (ResetI) begin
      state  <= IDLE;
      last_d <= 1'b1;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && (!req_d || last_d)) begin
            state  <= OWN_I;
            last_d <= 1'b0;
          end else if (req_d) begin
            state  <= OWN_D;
            last_d <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        // Leaving through IDLE guarantees a strobe-low cycle between owners.
        OWN_I: begin
          if (!bus.ICycI) state <= IDLE;
          else            state <= OWN_I;
        end
        OWN_D: begin
          if (!bus.DCycI) state <= IDLE;
          else            state <= OWN_D;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Grant is kept on timeout; only the count restarts.
      if (!stalled || timeout) cnt <= '0;
      else                     cnt <= cnt + CW'(1);
    end
  end

  // Bridge-side mux and owner-only response steering.
  always_comb begin
    bus.MCycO        = 1'b0;
    bus.MStbO        = m_stb;
    bus.MWeO         = 1'b0;
    bus.MSignedO     = 1'b0;
    bus.MAdrO        = 64'd0;
    bus.MSizO        = 2'd0;
    bus.MDatO        = 64'd0;
    bus.IAckO        = 1'b0;
    bus.IErrAlignO   = 1'b0;
    bus.IErrTimeoutO = 1'b0;
    bus.DAckO        = 1'b0;
    bus.DErrAlignO   = 1'b0;
    bus.DErrTimeoutO = 1'b0;
    bus.RDatO        = bus.MDatI;
    case (state)
      OWN_I: begin
        // Instruction fetch is read-only: no write enable, no write data.
        bus.MCycO        = bus.ICycI;
        bus.MSignedO     = bus.ISignedI;
        bus.MAdrO        = bus.IAdrI;
        bus.MSizO        = bus.ISizI;
        bus.IAckO        = bus.MAckI & bus.IStbI;
        bus.IErrAlignO   = bus.MErrAlignI & bus.IStbI;
        bus.IErrTimeoutO = timeout;
      end
      OWN_D: begin
        bus.MCycO        = bus.DCycI;
        bus.MWeO         = bus.DWeI;
        bus.MSignedO     = bus.DSignedI;
        bus.MAdrO        = bus.DAdrI;
        bus.MSizO        = bus.DSizI;
        bus.MDatO        = bus.DDatI;
        bus.DAckO        = bus.MAckI & bus.DStbI;
        bus.DErrAlignO   = bus.MErrAlignI & bus.DStbI;
        bus.DErrTimeoutO = timeout;
      end
      default: begin
        bus.MCycO = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bottleneck_arbiter.sv
// Self-checking bench for bottleneck_arbiter: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level
// reference model (owner id, tie preference, length of the current stall).
module tb_bottleneck_arbiter;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: owner 0 = none, 1 = I, 2 = D.
  int owner_m;
  bit prefer_i_m;
  int stall_run_m;
  bit stalled_m;

  bottleneck_arbiter_if bus();

  bottleneck_arbiter #(.TIMEOUT(T), .CW(8)) dut (
    .ClkI  (clk),
    .ResetI(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner_m     = 0;
    prefer_i_m  = 1'b1;
    stall_run_m = 0;
    stalled_m   = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.ICycI = 1'b0; bus.IStbI = 1'b0; bus.IAdrI = 64'd0; bus.ISizI = 2'd0; bus.ISignedI = 1'b0;
    bus.DCycI = 1'b0; bus.DStbI = 1'b0; bus.DWeI = 1'b0; bus.DSignedI = 1'b0;
    bus.DAdrI = 64'd0; bus.DSizI = 2'd0; bus.DDatI = 64'd0;
    bus.MAckI = 1'b0; bus.MErrAlignI = 1'b0; bus.MDatI = 64'd0;
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic check_cycle();
    logic       e_cyc, e_stb, e_we, e_sgn, fire;
    logic [63:0] e_adr, e_dat;
    logic [1:0]  e_siz;
    #1;
    if (rst) model_reset();
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sgn = 1'b0;
    e_adr = 64'd0; e_dat = 64'd0; e_siz = 2'd0;
    if (owner_m == 1) begin
      e_cyc = bus.ICycI; e_stb = bus.ICycI & bus.IStbI; e_sgn = bus.ISignedI;
      e_adr = bus.IAdrI; e_siz = bus.ISizI;
    end else if (owner_m == 2) begin
      e_cyc = bus.DCycI; e_stb = bus.DCycI & bus.DStbI; e_sgn = bus.DSignedI;
      e_adr = bus.DAdrI; e_siz = bus.DSizI; e_we = bus.DWeI; e_dat = bus.DDatI;
    end
    stalled_m = e_stb && !bus.MAckI && !bus.MErrAlignI;
    // Every T-th consecutive unanswered strobe cycle raises a timeout.
    fire = stalled_m && (((stall_run_m + 1) % T) == 0);
    check("mcyc",  bus.MCycO, e_cyc);
    check("mstb",  bus.MStbO, e_stb);
    check("mwe",   bus.MWeO, e_we);
    check("msgn",  bus.MSignedO, e_sgn);
    check("madr",  bus.MAdrO, e_adr);
    check("msiz",  bus.MSizO, e_siz);
    check("mdat",  bus.MDatO, e_dat);
    check("rdat",  bus.RDatO, bus.MDatI);
    check("iack",  bus.IAckO, (owner_m == 1) && bus.MAckI && bus.IStbI);
    check("ialgn", bus.IErrAlignO, (owner_m == 1) && bus.MErrAlignI && bus.IStbI);
    check("itmo",  bus.IErrTimeoutO, (owner_m == 1) && fire);
    check("dack",  bus.DAckO, (owner_m == 2) && bus.MAckI && bus.DStbI);
    check("dalgn", bus.DErrAlignO, (owner_m == 2) && bus.MErrAlignI && bus.DStbI);
    check("dtmo",  bus.DErrTimeoutO, (owner_m == 2) && fire);
  endtask

  // Advance to the rising edge and move the model to its next state.
  task automatic tick();
    bit ri, rd;
    @(posedge clk);
    ri = bus.ICycI && bus.IStbI;
    rd = bus.DCycI && bus.DStbI;
    if (rst) begin
      model_reset();
    end else if (owner_m == 0) begin
      if (ri && (!rd || prefer_i_m)) begin
        owner_m = 1; prefer_i_m = 1'b0;
      end else if (rd) begin
        owner_m = 2; prefer_i_m = 1'b1;
      end
      stall_run_m = 0;
    end else if ((owner_m == 1 && !bus.ICycI) || (owner_m == 2 && !bus.DCycI)) begin
      owner_m = 0; stall_run_m = 0;
    end else begin
      stall_run_m = stalled_m ? stall_run_m + 1 : 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    check_cycle();
    check("rst_mcyc", bus.MCycO, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    check_cycle();
    tick();
  endtask

  initial begin
    model_reset();
    clear_inputs();
    do_reset();

    // 64-bit I read at 0x1000, then an acked beat with read data.
    @(negedge clk);
    bus.ICycI = 1'b1; bus.IStbI = 1'b1; bus.IAdrI = 64'h1000; bus.ISizI = 2'd3;
    check_cycle();
    check("t1_stb0", bus.MStbO, 1'b0);
    tick();
    @(negedge clk);
    bus.MAckI = 1'b1; bus.MDatI = 64'h1122334455667788;
    check_cycle();
    check("t1_stb1", bus.MStbO, 1'b1);
    check("t1_siz",  bus.MSizO, 2'd3);
    check("t1_adr",  bus.MAdrO, 64'h1000);
    check("t1_we",   bus.MWeO, 1'b0);
    check("t1_iack", bus.IAckO, 1'b1);
    check("t1_rdat", bus.RDatO, 64'h1122334455667788);
    check("t1_dack", bus.DAckO, 1'b0);
    tick();

    // Three ties in a row: grants alternate I, D, I with an IDLE gap.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      logic [63:0] exp_adr;
      exp_adr = (k == 1) ? 64'h200 : 64'h100;
      @(negedge clk);
      bus.ICycI = 1'b1; bus.IStbI = 1'b1; bus.IAdrI = 64'h100;
      bus.DCycI = 1'b1; bus.DStbI = 1'b1; bus.DAdrI = 64'h200; bus.MAckI = 1'b0;
      check_cycle();
      check("t2_gap", bus.MStbO, 1'b0);
      tick();
      @(negedge clk);
      bus.MAckI = 1'b1;
      check_cycle();
      check("t2_owner", bus.MAdrO, exp_adr);
      tick();
      @(negedge clk);
      bus.MAckI = 1'b0;
      if (k == 1) begin bus.DCycI = 1'b0; bus.DStbI = 1'b0; end
      else        begin bus.ICycI = 1'b0; bus.IStbI = 1'b0; end
      check_cycle();
      tick();
    end

    // D 32-bit write holds off a pending I request until D drops + IDLE.
    do_reset();
    @(negedge clk);
    bus.DCycI = 1'b1; bus.DStbI = 1'b1; bus.DWeI = 1'b1; bus.DAdrI = 64'h2004;
    bus.DSizI = 2'd2; bus.DDatI = 64'hDEADBEEF;
    check_cycle();
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.ICycI = 1'b1; bus.IStbI = 1'b1; bus.IAdrI = 64'h4000;
      bus.MAckI = (c == 2);
      check_cycle();
      check("t3_mdat", bus.MDatO, 64'hDEADBEEF);
      check("t3_mwe",  bus.MWeO, 1'b1);
      check("t3_iack", bus.IAckO, 1'b0);
      tick();
    end
    @(negedge clk);
    bus.DCycI = 1'b0; bus.DStbI = 1'b0; bus.MAckI = 1'b0;
    check_cycle();
    check("t3_drop", bus.MCycO, 1'b0);
    tick();
    @(negedge clk);
    check_cycle();
    check("t3_idle", bus.MStbO, 1'b0);
    tick();
    @(negedge clk);
    check_cycle();
    check("t3_igrant", bus.MAdrO, 64'h4000);
    tick();

    // D misaligned 16-bit access answered with an alignment error.
    do_reset();
    @(negedge clk);
    bus.DCycI = 1'b1; bus.DStbI = 1'b1; bus.DAdrI = 64'h3001; bus.DSizI = 2'd1;
    check_cycle();
    tick();
    @(negedge clk);
    bus.MErrAlignI = 1'b1;
    check_cycle();
    check("t4_dalgn", bus.DErrAlignO, 1'b1);
    check("t4_ialgn", bus.IErrAlignO, 1'b0);
    check("t4_dtmo",  bus.DErrTimeoutO, 1'b0);
    tick();

    // Watchdog: I strobes with no ack; pulses on strobe cycles 4 and 8.
    do_reset();
    @(negedge clk);
    bus.ICycI = 1'b1; bus.IStbI = 1'b1; bus.IAdrI = 64'h80;
    check_cycle();
    tick();
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      check_cycle();
      check("t5_tmo",   bus.IErrTimeoutO, (s % 4) == 0);
      check("t5_grant", bus.MCycO, 1'b1);
      tick();
    end

    // Reset during D ownership with an ack pending, then a tie grants I.
    do_reset();
    @(negedge clk);
    bus.DCycI = 1'b1; bus.DStbI = 1'b1; bus.DAdrI = 64'h500;
    check_cycle();
    tick();
    @(negedge clk);
    bus.MAckI = 1'b1;
    rst = 1'b1;
    check_cycle();
    check("t6_mcyc", bus.MCycO, 1'b0);
    check("t6_mstb", bus.MStbO, 1'b0);
    check("t6_dack", bus.DAckO, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b0; bus.MAckI = 1'b0;
    bus.ICycI = 1'b1; bus.IStbI = 1'b1; bus.IAdrI = 64'h600;
    check_cycle();
    tick();
    @(negedge clk);
    check_cycle();
    check("t6_igrant", bus.MAdrO, 64'h600);
    tick();

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      if (bus.ICycI) begin if ($urandom_range(0, 5) == 0) bus.ICycI = 1'b0; end
      else if ($urandom_range(0, 2) == 0) bus.ICycI = 1'b1;
      if (bus.DCycI) begin if ($urandom_range(0, 5) == 0) bus.DCycI = 1'b0; end
      else if ($urandom_range(0, 2) == 0) bus.DCycI = 1'b1;
      bus.IStbI = bus.ICycI & ($urandom_range(0, 3) != 0);
      bus.DStbI = bus.DCycI & ($urandom_range(0, 3) != 0);
      bus.IAdrI = {$urandom, $urandom};
      bus.DAdrI = {$urandom, $urandom};
      bus.DDatI = {$urandom, $urandom};
      bus.MDatI = {$urandom, $urandom};
      bus.ISizI = 2'($urandom_range(0, 3));
      bus.DSizI = 2'($urandom_range(0, 3));
      bus.ISignedI = 1'($urandom_range(0, 1));
      bus.DSignedI = 1'($urandom_range(0, 1));
      bus.DWeI = 1'($urandom_range(0, 1));
      bus.MAckI = ($urandom_range(0, 4) == 0);
      bus.MErrAlignI = ($urandom_range(0, 11) == 0);
      check_cycle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bottleneck_arbiter.md
Name: bottleneck_arbiter

Overview:
- Two-master arbiter that shares the single 64-bit master port of the Bottleneck bridge between the KCP53K instruction-fetch port (I) and data port (D).
- Grants bus ownership by round-robin on contention and holds the grant for the owner's whole Wishbone cycle.
- Steers the bridge's ack, read data and alignment error back to the owner only.
- Runs a no-ack watchdog that reports a stalled access to the owner.

Parameters:
TIMEOUT, 255, cycles with owner strobe high and no MAckI before a timeout error; range 1..255
CW, 8, watchdog counter width; must hold TIMEOUT

Ports:
ClkI  in  1  clock; all state updates on rising edge
ResetI  in  1  asynchronous, active-high reset
ICycI, IStbI  in  1 each  I-port cycle and strobe
IAdrI  in  64  I-port byte address
ISizI  in  2  I-port size (0=8b, 1=16b, 2=32b, 3=64b)
ISignedI  in  1  I-port sign-extend request
IAckO, IErrAlignO, IErrTimeoutO  out  1 each  I-port ack, misalignment error, watchdog error
DCycI, DStbI, DWeI, DSignedI  in  1 each  D-port cycle, strobe, write enable, sign-extend request
DAdrI  in  64  D-port byte address
DSizI  in  2  D-port size
DDatI  in  64  D-port write data
DAckO, DErrAlignO, DErrTimeoutO  out  1 each  D-port ack, misalignment error, watchdog error
RDatO  out  64  read data to both ports (MDatI passthrough); valid only with the owner's ack
MCycO, MStbO, MWeO, MSignedO  out  1 each  to bridge
MAdrO  out  64  to bridge
MSizO  out  2  to bridge
MDatO  out  64  to bridge
MAckI, MErrAlignI  in  1 each  from bridge
MDatI  in  64  from bridge

Behaviour:
- State register: IDLE, OWN_I, OWN_D.
- Priority register: last = I or D.
- Watchdog counter: cnt, CW bits.
- Reset, asynchronous: state=IDLE, last=D (I wins the first tie), cnt=0.
- All outputs are 0 during and after reset until a grant is made. RDatO passes MDatI regardless of state.
- Request definition: reqX = XCycI & XStbI.
- IDLE:
  - reqI only -> OWN_I.
  - reqD only -> OWN_D.
  - Both -> grant the port that is not `last`.
  - Grant takes effect next edge; a request first raised in cycle n sees MStbO high in cycle n+1 at the earliest.
  - On every grant, `last` is updated to the granted port.
- OWN_X (X = I or D):
  - MCycO = XCycI and MStbO = XStbI, combinational.
  - MAdrO, MSizO, MSignedO are muxed from X.
  - MWeO = DWeI when X=D; 0 when X=I (fetch is read-only).
  - MDatO = DDatI when X=D; 0 otherwise.
  - XAckO = MAckI & XStbI. XErrAlignO = MErrAlignI & XStbI.
  - The non-owner's ack and error outputs are held at 0.
  - Owner may issue back-to-back strobes within one cycle (Cyc held) with no bubble.
  - XCycI low -> MCycO/MStbO drop in the same cycle; next edge -> IDLE.
  - Minimum one IDLE cycle between owners; this gives the bridge's internal ack1..ack3 sequence state a clean strobe-low cycle.
  - The non-owner's requests are ignored while a grant is held. Starvation is bounded by the owner's cycle length.
- Watchdog:
  - cnt clears when not in OWN_*, when MStbO=0, or when MAckI=1 or MErrAlignI=1.
  - Otherwise cnt increments each cycle.
  - When cnt == TIMEOUT-1 and still no ack: XErrTimeoutO=1 for exactly one cycle, and cnt clears.
  - The arbiter does not drop the grant on timeout; the owner decides.
- Simultaneous events:
  - MAckI and timeout in the same cycle -> ack wins, no timeout.
  - Owner Cyc drops in the same cycle as MAckI -> ack is still delivered, then IDLE.
  - Requester withdrawing before grant in IDLE -> no grant; re-evaluated each cycle.
- Reset mid-operation: ownership is abandoned immediately, all M outputs go to 0 asynchronously, and no ack or error is emitted.

Test Plan:
- Reset, then I requests 64-bit read at 0x1000 -> MStbO=1 one cycle later; MSizO=3, MAdrO=0x1000, MWeO=0. MAckI with MDatI=0x1122334455667788 -> IAckO=1, RDatO=0x1122334455667788, DAckO=0.
- I and D request in the same IDLE cycle, three times after reset, each cycle dropping after its ack -> grants go I, D, I; an IDLE cycle separates each owner.
- D owns and issues a 32-bit write of 0xDEADBEEF to 0x2004 while I requests -> I is not granted until DCycI drops plus one IDLE cycle; MDatO=0xDEADBEEF, MWeO=1.
- D issues a 16-bit access at odd address 0x3001 and the bridge raises MErrAlignI -> DErrAlignO=1 the same cycle, IErrAlignO=0, no watchdog error.
- TIMEOUT=4, I strobes and MAckI is held low -> IErrTimeoutO pulses in the 4th and 8th strobe cycles; grant remains I.
- ResetI asserted mid D-ownership, with MAckI pending -> MCycO=MStbO=DAckO=0 immediately; after release, an I/D tie grants I.
